elevator_call_sched: RTL and testbench

- Upstream request scheduler for the 3-floor elevator controller.
- Latches car/hall call buttons for floors 1–3 and picks the next target with a SCAN (keep-direction) policy.
- Drives the controller's 2-bit floor request code and watches the controller's 2-bit position code to detect arrival.
- On arrival, clears the call and holds a door-dwell interval before issuing the next request.

---
 rtl/elevator_call_sched.sv | 178 +++++++++++++++++
 tb/tb_elevator_call_sched.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/elevator_call_sched.sv
// rtl/elevator_call_sched.sv - SCAN call scheduler for a 3-floor elevator (optional CALL_TIMEOUT_EN)
module elevator_call_sched #(
  parameter int unsigned DWELL_CYC   = 4,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] btn,
  input  logic [1:0] cur_pos,
  output logic [1:0] floor_req,
  output logic       door_open,
  output logic       dir_up,
  output logic [2:0] pend,
  output logic       busy,
  output logic       fault
);

  typedef enum logic [1:0] {IDLE, SERVE, DWELL} state_t;

  localparam logic [7:0] DWELL_LD = 8'(DWELL_CYC);

  state_t     state, state_nxt;
  logic [2:0] btn_q, rise, pend_nxt, tgt_mask;
  logic [1:0] tgt, tgt_nxt, req_nxt, sel;
  logic       door_nxt, dir_nxt;
  logic [7:0] dwell_cnt, dwell_nxt;
  logic [1:0] cur_idx, up_idx, dn_idx;
  logic       moving, arrived, up_ok, dn_ok;

`ifdef CALL_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);
  logic [15:0] to_cnt, to_nxt;
  logic        fault_q, fault_nxt;
  assign fault = fault_q;
`else
  // Timeout disabled; the parameter stays for a uniform instantiation interface.
  assign fault = 1'b0 & (TIMEOUT_CYC == 0);
`endif

  assign rise     = btn & ~btn_q;
  assign moving   = (cur_pos == 2'b10);
  assign tgt_mask = 3'b001 << tgt;
  assign arrived  = !moving && (cur_idx == tgt);
  assign busy     = (state != IDLE);

  always_comb begin
    case (cur_pos)
      2'b01:   cur_idx = 2'd1;
      2'b11:   cur_idx = 2'd2;
      default: cur_idx = 2'd0;
    endcase
  end

  // Nearest pending floor at/above (up_idx) and at/below (dn_idx) the car.
  always_comb begin
    up_ok  = 1'b0;
    up_idx = 2'd0;
    dn_ok  = 1'b0;
    dn_idx = 2'd0;
    for (int i = 2; i >= 0; i--) begin
      if (pend[i] && (2'(i) >= cur_idx)) begin
        up_ok  = 1'b1;
        up_idx = 2'(i);
      end
    end
    for (int i = 0; i < 3; i++) begin
      if (pend[i] && (2'(i) <= cur_idx)) begin
        dn_ok  = 1'b1;
        dn_idx = 2'(i);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    pend_nxt  = pend | rise;
    tgt_nxt   = tgt;
    req_nxt   = floor_req;
    door_nxt  = door_open;
    dir_nxt   = dir_up;
    dwell_nxt = dwell_cnt;
    sel       = 2'd0;
`ifdef CALL_TIMEOUT_EN
    to_nxt    = to_cnt;
    fault_nxt = fault_q;
`endif
    case (state)
      IDLE: begin
        req_nxt = 2'b00;
        if ((pend != 3'b000) && !moving) begin
          if (dir_up) begin
            if (up_ok) sel = up_idx;
            else begin
              sel     = dn_idx;
              dir_nxt = 1'b0;
            end
          end else begin
            if (dn_ok) sel = dn_idx;
            else begin
              sel     = up_idx;
              dir_nxt = 1'b1;
            end
          end
          tgt_nxt   = sel;
          req_nxt   = sel + 2'd1;
          state_nxt = SERVE;
`ifdef CALL_TIMEOUT_EN
          to_nxt    = 16'd0;
`endif
        end
      end
      SERVE: begin
        if (arrived) begin
          pend_nxt  = (pend | rise) & ~tgt_mask;
          req_nxt   = 2'b00;
          dwell_nxt = DWELL_LD;
          door_nxt  = 1'b1;
          state_nxt = DWELL;
        end
`ifdef CALL_TIMEOUT_EN
        else if (to_cnt == TO_LAST) begin
          fault_nxt = 1'b1;
          pend_nxt  = (pend | rise) & ~tgt_mask;
          req_nxt   = 2'b00;
          state_nxt = IDLE;
        end else begin
          to_nxt = to_cnt + 16'd1;
        end
`endif
      end
      DWELL: begin
        // Pressing the served floor's button holds the door rather than queueing a call.
        pend_nxt = pend | (rise & ~tgt_mask);
        if ((rise & tgt_mask) != 3'b000) begin
          dwell_nxt = DWELL_LD;
        end else if (dwell_cnt <= 8'd1) begin
          dwell_nxt = 8'd0;
          door_nxt  = 1'b0;
          state_nxt = IDLE;
        end else begin
          dwell_nxt = dwell_cnt - 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      btn_q     <= 3'b000;
      pend      <= 3'b000;
      tgt       <= 2'd0;
      floor_req <= 2'b00;
      door_open <= 1'b0;
      dir_up    <= 1'b1;
      dwell_cnt <= 8'd0;
`ifdef CALL_TIMEOUT_EN
      to_cnt    <= 16'd0;
      fault_q   <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      btn_q     <= btn;
      pend      <= pend_nxt;
      tgt       <= tgt_nxt;
      floor_req <= req_nxt;
      door_open <= door_nxt;
      dir_up    <= dir_nxt;
      dwell_cnt <= dwell_nxt;
`ifdef CALL_TIMEOUT_EN
      to_cnt    <= to_nxt;
      fault_q   <= fault_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_elevator_call_sched.sv
// tb/tb_elevator_call_sched.sv - directed self-checking bench for elevator_call_sched
module tb_elevator_call_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] btn;
  logic [1:0] cur_pos;
  logic [1:0] floor_req;
  logic       door_open, dir_up, busy, fault;
  logic [2:0] pend;
  int         errors = 0;
  int         checks = 0;

  elevator_call_sched #(.DWELL_CYC(4), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst(rst), .btn(btn), .cur_pos(cur_pos),
    .floor_req(floor_req), .door_open(door_open), .dir_up(dir_up),
    .pend(pend), .busy(busy), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0; btn = 3'b111; cur_pos = 2'b00;
    tick; tick;
    checks++; if (floor_req !== 2'b00) begin errors++; $display("FAIL reset_req got=%b exp=00", floor_req); end
    checks++; if (door_open !== 1'b0) begin errors++; $display("FAIL reset_door got=%b exp=0", door_open); end
    checks++; if (dir_up !== 1'b1) begin errors++; $display("FAIL reset_dir got=%b exp=1", dir_up); end
    checks++; if (pend !== 3'b000) begin errors++; $display("FAIL reset_pend got=%b exp=000", pend); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault got=%b exp=0", fault); end
    rst = 1'b1; btn = 3'b000;
    tick; tick;
    checks++; if (pend !== 3'b000) begin errors++; $display("FAIL post_reset_pend got=%b exp=000", pend); end
  endtask

  task automatic test_single_call;
    btn = 3'b100; tick;
    checks++; if (pend !== 3'b100) begin errors++; $display("FAIL single_pend got=%b exp=100", pend); end
    checks++; if (floor_req !== 2'b00) begin errors++; $display("FAIL single_req_early got=%b exp=00", floor_req); end
    btn = 3'b000; tick;
    checks++; if (floor_req !== 2'b11) begin errors++; $display("FAIL single_req got=%b exp=11", floor_req); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got=%b exp=1", busy); end
    cur_pos = 2'b10; tick;
    checks++; if (floor_req !== 2'b11) begin errors++; $display("FAIL single_req_moving got=%b exp=11", floor_req); end
    cur_pos = 2'b11; tick;
    checks++; if (pend !== 3'b000) begin errors++; $display("FAIL single_arr_pend got=%b exp=000", pend); end
    checks++; if (floor_req !== 2'b00) begin errors++; $display("FAIL single_arr_req got=%b exp=00", floor_req); end
    checks++; if (door_open !== 1'b1) begin errors++; $display("FAIL single_door1 got=%b exp=1", door_open); end
    tick; tick; tick;
    checks++; if (door_open !== 1'b1) begin errors++; $display("FAIL single_door4 got=%b exp=1", door_open); end
    tick;
    checks++; if (door_open !== 1'b0) begin errors++; $display("FAIL single_door_end got=%b exp=0", door_open); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle got=%b exp=0", busy); end
  endtask

  task automatic test_scan_order;
    cur_pos = 2'b01; btn = 3'b101; tick;
    checks++; if (pend !== 3'b101) begin errors++; $display("FAIL scan_pend got=%b exp=101", pend); end
    btn = 3'b000; tick;
    checks++; if (floor_req !== 2'b11) begin errors++; $display("FAIL scan_first got=%b exp=11", floor_req); end
    checks++; if (dir_up !== 1'b1) begin errors++; $display("FAIL scan_dir1 got=%b exp=1", dir_up); end
    cur_pos = 2'b11; tick;
    checks++; if (pend !== 3'b001) begin errors++; $display("FAIL scan_pend2 got=%b exp=001", pend); end
    tick; tick; tick; tick;
    tick;
    checks++; if (floor_req !== 2'b01) begin errors++; $display("FAIL scan_second got=%b exp=01", floor_req); end
    checks++; if (dir_up !== 1'b0) begin errors++; $display("FAIL scan_dir0 got=%b exp=0", dir_up); end
    cur_pos = 2'b00; tick;
    checks++; if (door_open !== 1'b1) begin errors++; $display("FAIL scan_arr2 got=%b exp=1", door_open); end
    tick; tick; tick; tick;
  endtask

  task automatic test_current_floor;
    cur_pos = 2'b00; btn = 3'b001; tick;
    btn = 3'b000; tick;
    checks++; if (floor_req !== 2'b01) begin errors++; $display("FAIL cur_req got=%b exp=01", floor_req); end
    tick;
    checks++; if (door_open !== 1'b1) begin errors++; $display("FAIL cur_arrive got=%b exp=1", door_open); end
    tick; tick;
    btn = 3'b001; tick;
    checks++; if (pend !== 3'b000) begin errors++; $display("FAIL cur_repress_pend got=%b exp=000", pend); end
    btn = 3'b000; tick; tick; tick;
    checks++; if (door_open !== 1'b1) begin errors++; $display("FAIL cur_extend got=%b exp=1", door_open); end
    checks++; if (pend !== 3'b000) begin errors++; $display("FAIL cur_pend_hold got=%b exp=000", pend); end
    tick;
    checks++; if (door_open !== 1'b0) begin errors++; $display("FAIL cur_extend_end got=%b exp=0", door_open); end
  endtask

  task automatic test_held_button;
    int stray;
    stray = 0;
    cur_pos = 2'b00; btn = 3'b010; tick;
    checks++; if (pend !== 3'b010) begin errors++; $display("FAIL held_pend got=%b exp=010", pend); end
    tick;
    checks++; if (floor_req !== 2'b10) begin errors++; $display("FAIL held_req got=%b exp=10", floor_req); end
    checks++; if (dir_up !== 1'b1) begin errors++; $display("FAIL held_dir got=%b exp=1", dir_up); end
    cur_pos = 2'b10; tick;
    cur_pos = 2'b01; tick;
    tick; tick; tick; tick;
    for (int i = 0; i < 13; i++) begin
      tick;
      if (pend !== 3'b000 || busy !== 1'b0) stray++;
    end
    checks++; if (stray !== 0) begin errors++; $display("FAIL held_retrigger got=%0d exp=0", stray); end
    btn = 3'b000; tick;
    checks++; if (pend !== 3'b000) begin errors++; $display("FAIL held_release got=%b exp=000", pend); end
  endtask

  task automatic test_back_to_back;
    cur_pos = 2'b01; btn = 3'b100; tick;
    btn = 3'b000; tick;
    checks++; if (floor_req !== 2'b11) begin errors++; $display("FAIL b2b_req got=%b exp=11", floor_req); end
    btn = 3'b001; tick;
    checks++; if (pend !== 3'b101) begin errors++; $display("FAIL b2b_pend got=%b exp=101", pend); end
    checks++; if (floor_req !== 2'b11) begin errors++; $display("FAIL b2b_keep_tgt got=%b exp=11", floor_req); end
    btn = 3'b000; tick;
    cur_pos = 2'b11; btn = 3'b100; tick;
    checks++; if (pend !== 3'b001) begin errors++; $display("FAIL b2b_clear_wins got=%b exp=001", pend); end
    tick; tick; tick;
    btn = 3'b000; tick;
    tick;
    checks++; if (floor_req !== 2'b01) begin errors++; $display("FAIL b2b_next got=%b exp=01", floor_req); end
    checks++; if (dir_up !== 1'b0) begin errors++; $display("FAIL b2b_dir got=%b exp=0", dir_up); end
  endtask

`ifdef CALL_TIMEOUT_EN
  task automatic test_timeout;
    rst = 1'b0; btn = 3'b000; cur_pos = 2'b00; tick;
    rst = 1'b1;
    btn = 3'b100; tick;
    btn = 3'b000; tick;
    cur_pos = 2'b10; btn = 3'b001; tick;
    btn = 3'b000;
    for (int i = 0; i < 6; i++) tick;
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL to_early got=%b exp=0", fault); end
    checks++; if (floor_req !== 2'b11) begin errors++; $display("FAIL to_req_early got=%b exp=11", floor_req); end
    tick;
    checks++; if (fault !== 1'b1) begin errors++; $display("FAIL to_fault got=%b exp=1", fault); end
    checks++; if (pend !== 3'b001) begin errors++; $display("FAIL to_pend got=%b exp=001", pend); end
    checks++; if (floor_req !== 2'b00) begin errors++; $display("FAIL to_req got=%b exp=00", floor_req); end
    cur_pos = 2'b00; tick;
    checks++; if (floor_req !== 2'b01) begin errors++; $display("FAIL to_next got=%b exp=01", floor_req); end
    tick;
    checks++; if (door_open !== 1'b1) begin errors++; $display("FAIL to_served got=%b exp=1", door_open); end
    checks++; if (fault !== 1'b1) begin errors++; $display("FAIL to_sticky got=%b exp=1", fault); end
  endtask
`endif

  initial begin
    rst = 1'b0; btn = 3'b000; cur_pos = 2'b00;
    test_reset;
    test_single_call;
    test_scan_order;
    test_current_floor;
    test_held_button;
    test_back_to_back;
`ifdef CALL_TIMEOUT_EN
    test_timeout;
`endif
    rst = 1'b0; tick;
    checks++; if (pend !== 3'b000 || busy !== 1'b0 || dir_up !== 1'b1) begin
      errors++; $display("FAIL final_reset got=%b/%b/%b exp=000/0/1", pend, busy, dir_up);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
